// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: oversampled serial frame receiver. It captures start, data,
// optional parity and stop bits, hands them to an external error checker for
// one clock, then delivers the byte together with the checker's verdict.
module rx_frame_ctrl #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       data_tx,
  input  logic [1:0] parity_type,
  input  logic [2:0] error_flag,
  output logic [7:0] raw_data,
  output logic       start_bit,
  output logic       parity_bit,
  output logic       stop_bit,
  output logic       recieved_flag,
  output logic [1:0] parity_type_lat,
  output logic [7:0] data_out,
  output logic [2:0] frame_error,
  output logic       data_valid,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    CHECK,
    REPORT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    raw_data_q, raw_data_d;
  logic          start_bit_q, start_bit_d;
  logic          parity_bit_q, parity_bit_d;
  logic          stop_bit_q, stop_bit_d;
  logic [1:0]    ptl_q, ptl_d;
  logic [7:0]    data_out_q, data_out_d;
  logic [2:0]    frame_error_q, frame_error_d;

  // State and datapath registers, cleared asynchronously so a reset aborts a frame at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      raw_data_q    <= '0;
      start_bit_q   <= 1'b0;
      parity_bit_q  <= 1'b0;
      stop_bit_q    <= 1'b0;
      ptl_q         <= '0;
      data_out_q    <= '0;
      frame_error_q <= '0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      raw_data_q    <= raw_data_d;
      start_bit_q   <= start_bit_d;
      parity_bit_q  <= parity_bit_d;
      stop_bit_q    <= stop_bit_d;
      ptl_q         <= ptl_d;
      data_out_q    <= data_out_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Next-state and datapath updates; counters only move on baud_tick
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    raw_data_d    = raw_data_q;
    start_bit_d   = start_bit_q;
    parity_bit_d  = parity_bit_q;
    stop_bit_d    = stop_bit_q;
    ptl_d         = ptl_q;
    data_out_d    = data_out_q;
    frame_error_d = frame_error_q;

    case (state_q)
      IDLE: begin
        if (baud_tick && !data_tx) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          ptl_d      = parity_type;
        end
      end

      START: begin
        if (baud_tick) begin
          if (tick_cnt_q == HALF_LAST) begin
            tick_cnt_d = '0;
            if (data_tx) begin
              state_d = IDLE;
            end else begin
              start_bit_d = 1'b0;
              state_d     = DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end

      DATA: begin
        if (baud_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            raw_data_d = {data_tx, raw_data_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (ptl_q == 2'b01 || ptl_q == 2'b10) begin
                state_d = PARITY;
              end else begin
                parity_bit_d = 1'b0;
                state_d      = STOP;
              end
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end

      PARITY: begin
        if (baud_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d   = '0;
            parity_bit_d = data_tx;
            state_d      = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            stop_bit_d = data_tx;
            state_d    = CHECK;
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end

      // Checker result is taken while the frame fields are held stable, so
      // data_out/frame_error are already valid in the cycle data_valid is high.
      CHECK: begin
        data_out_d    = raw_data_q;
        frame_error_d = error_flag;
        state_d       = REPORT;
      end

      REPORT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign raw_data        = raw_data_q;
  assign start_bit       = start_bit_q;
  assign parity_bit      = parity_bit_q;
  assign stop_bit        = stop_bit_q;
  assign parity_type_lat = ptl_q;
  assign data_out        = data_out_q;
  assign frame_error     = frame_error_q;
  assign recieved_flag   = (state_q == CHECK);
  assign data_valid      = (state_q == REPORT);
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with OVERSAMPLE=16 and ticks every 4 clocks.
module tb_rx_frame_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       baud_tick;
  logic       data_tx;
  logic [1:0] parity_type;
  logic [2:0] error_flag;
  logic [7:0] raw_data;
  logic       start_bit;
  logic       parity_bit;
  logic       stop_bit;
  logic       recieved_flag;
  logic [1:0] parity_type_lat;
  logic [7:0] data_out;
  logic [2:0] frame_error;
  logic       data_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int rf_cnt = 0;
  int dv_cnt = 0;

  rx_frame_ctrl #(.OVERSAMPLE(16)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .baud_tick      (baud_tick),
    .data_tx        (data_tx),
    .parity_type    (parity_type),
    .error_flag     (error_flag),
    .raw_data       (raw_data),
    .start_bit      (start_bit),
    .parity_bit     (parity_bit),
    .stop_bit       (stop_bit),
    .recieved_flag  (recieved_flag),
    .parity_type_lat(parity_type_lat),
    .data_out       (data_out),
    .frame_error    (frame_error),
    .data_valid     (data_valid),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (recieved_flag === 1'b1) rf_cnt++;
    if (data_valid === 1'b1) dv_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    baud_tick = 1'b1;
    @(posedge clock);
    #1;
    baud_tick = 1'b0;
  endtask

  task automatic gap();
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_raw"}, 32'(raw_data), 32'h0);
    chk({pfx, "_dout"}, 32'(data_out), 32'h0);
    chk({pfx, "_ferr"}, 32'(frame_error), 32'h0);
    chk({pfx, "_ptl"}, 32'(parity_type_lat), 32'h0);
    chk({pfx, "_start"}, 32'(start_bit), 32'h0);
    chk({pfx, "_par"}, 32'(parity_bit), 32'h0);
    chk({pfx, "_stop"}, 32'(stop_bit), 32'h0);
    chk({pfx, "_rf"}, 32'(recieved_flag), 32'h0);
    chk({pfx, "_dv"}, 32'(data_valid), 32'h0);
    chk({pfx, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Drives one ideal frame: line bit index = tick index / 16, detection at tick 0,
  // samples at ticks 8, 24, 40, ... Optional mid-frame parity_type change with a
  // long tick-free gap, and optional asynchronous reset at a given tick index.
  task automatic send_frame(input string tag, input logic [7:0] b, input logic [1:0] pt,
                            input bit use_par, input logic pbit, input logic sbit,
                            input logic [2:0] ef, input logic [1:0] exp_ptl,
                            input int mid_k, input logic [1:0] mid_pt, input int rst_at);
    logic [10:0] fb;
    int n;
    int last;
    int rf0;
    int dv0;
    fb    = '1;
    fb[0] = 1'b0;
    fb[8:1] = b;
    if (use_par) begin
      fb[9]  = pbit;
      fb[10] = sbit;
      n = 11;
    end else begin
      fb[9] = sbit;
      n = 10;
    end
    last = 8 + 16 * (n - 1);
    parity_type = pt;
    error_flag  = ef;
    rf0 = rf_cnt;
    dv0 = dv_cnt;
    for (int k = 0; k <= last; k++) begin
      if (k == rst_at) begin
        reset_n = 1'b0;
        #1;
        check_all_zero({tag, "_midrst"});
        data_tx = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        gap();
        chk({tag, "_rst_rfcnt"}, 32'(rf_cnt), 32'(rf0));
        chk({tag, "_rst_dvcnt"}, 32'(dv_cnt), 32'(dv0));
        return;
      end
      if (k == mid_k) begin
        parity_type = mid_pt;
        repeat (20) @(posedge clock);
        #1;
        chk({tag, "_gap_busy"}, 32'(busy), 32'h1);
        chk({tag, "_gap_ptl"}, 32'(parity_type_lat), 32'(exp_ptl));
      end
      data_tx = fb[k / 16];
      tick();
      if (k == 0) chk({tag, "_busy_start"}, 32'(busy), 32'h1);
      if (k != last) gap();
    end
    data_tx = 1'b1;
    // CHECK cycle
    chk({tag, "_rf"}, 32'(recieved_flag), 32'h1);
    chk({tag, "_raw"}, 32'(raw_data), 32'(b));
    chk({tag, "_start"}, 32'(start_bit), 32'h0);
    chk({tag, "_parbit"}, 32'(parity_bit), use_par ? 32'(pbit) : 32'h0);
    chk({tag, "_stopbit"}, 32'(stop_bit), 32'(sbit));
    chk({tag, "_ptl"}, 32'(parity_type_lat), 32'(exp_ptl));
    chk({tag, "_dv_early"}, 32'(data_valid), 32'h0);
    @(posedge clock);
    #1;
    // REPORT cycle
    chk({tag, "_rf_off"}, 32'(recieved_flag), 32'h0);
    chk({tag, "_dv"}, 32'(data_valid), 32'h1);
    chk({tag, "_dout"}, 32'(data_out), 32'(b));
    chk({tag, "_ferr"}, 32'(frame_error), 32'(ef));
    @(posedge clock);
    #1;
    chk({tag, "_dv_off"}, 32'(data_valid), 32'h0);
    chk({tag, "_idle"}, 32'(busy), 32'h0);
    chk({tag, "_dout_hold"}, 32'(data_out), 32'(b));
    chk({tag, "_rfcnt"}, 32'(rf_cnt), 32'(rf0 + 1));
    chk({tag, "_dvcnt"}, 32'(dv_cnt), 32'(dv0 + 1));
    gap();
  endtask

  initial begin
    int rf0;
    int dv0;
    reset_n     = 1'b0;
    baud_tick   = 1'b0;
    data_tx     = 1'b1;
    parity_type = 2'b00;
    error_flag  = 3'b000;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    gap();

    // Idle line with ticks must not start a frame
    tick();
    gap();
    chk("idle_high", 32'(busy), 32'h0);

    // 0x55, no parity, good stop, clean checker result
    send_frame("f55", 8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, -1, 2'b00, -1);

    // 0xA3, odd parity, parity bit 1
    send_frame("fA3", 8'hA3, 2'b01, 1'b1, 1'b1, 1'b1, 3'b000, 2'b01, -1, 2'b00, -1);

    // False start: low for 4 ticks then high before the mid-bit sample
    rf0 = rf_cnt;
    dv0 = dv_cnt;
    for (int k = 0; k <= 8; k++) begin
      data_tx = (k < 4) ? 1'b0 : 1'b1;
      tick();
      if (k == 0) chk("fs_busy", 32'(busy), 32'h1);
      gap();
    end
    chk("fs_idle", 32'(busy), 32'h0);
    repeat (6) @(posedge clock);
    #1;
    chk("fs_rfcnt", 32'(rf_cnt), 32'(rf0));
    chk("fs_dvcnt", 32'(dv_cnt), 32'(dv0));

    // 0x0F with a zero stop bit; checker flags stop error
    send_frame("f0F", 8'h0F, 2'b00, 1'b0, 1'b0, 1'b0, 3'b100, 2'b00, -1, 2'b00, -1);

    // Reset during the 5th data bit (ticks 80..95), then a clean 0xC4 frame
    send_frame("frst", 8'h12, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, -1, 2'b00, 85);
    send_frame("fC4", 8'hC4, 2'b00, 1'b0, 1'b0, 1'b1, 3'b010, 2'b00, -1, 2'b00, -1);

    // Even parity locked at start; parity_type changed to 00 mid-frame with a tick gap
    send_frame("f3C", 8'h3C, 2'b10, 1'b1, 1'b0, 1'b1, 3'b001, 2'b10, 60, 2'b00, -1);

    // Mode 11 behaves as no parity
    send_frame("fE1", 8'hE1, 2'b11, 1'b0, 1'b0, 1'b1, 3'b000, 2'b11, -1, 2'b00, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
